// File: rtl/gpio_pkg.sv
// Shared address-map constants for the GPIO bank: function codes in addr[7:5]
// and word register offsets in addr[4:2].
package gpio_pkg;

  typedef enum logic [2:0] {
    FN_PIN  = 3'd0,
    FN_DIR  = 3'd1,
    FN_RISE = 3'd2,
    FN_FALL = 3'd3,
    FN_FLAG = 3'd4,
    FN_WORD = 3'd5,
    FN_RSV6 = 3'd6,
    FN_RSV7 = 3'd7
  } fn_e;

  localparam logic [2:0] W_IN    = 3'd0;
  localparam logic [2:0] W_OUT   = 3'd1;
  localparam logic [2:0] W_DIR   = 3'd2;
  localparam logic [2:0] W_SET   = 3'd3;
  localparam logic [2:0] W_CLR   = 3'd4;
  localparam logic [2:0] W_TGL   = 3'd5;
  localparam logic [2:0] W_FLAG  = 3'd6;
  localparam logic [2:0] W_IRQEN = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop input synchroniser followed by a previous-sample register,
// producing the synchronised value and its per-bit rise/fall pulses.
module gpio_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_reg [STAGES];
  logic [WIDTH-1:0] prev_reg;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) stage_reg[0] <= '0;
    else         stage_reg[0] <= din;
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) stage_reg[gi] <= '0;
        else         stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) prev_reg <= '0;
    else         prev_reg <= stage_reg[STAGES-1];
  end

  assign sync_in = stage_reg[STAGES-1];
  assign rise    = sync_in & ~prev_reg;
  assign fall    = ~sync_in & prev_reg;

endmodule

// File: rtl/gpio_bank.sv
// Parametrised GPIO bank: bit and word access to pin state, atomic
// set/clear/toggle, edge-event flags with write-1-to-clear and a masked irq.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int          PINS        = 28,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'd0
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic            sel,
  input  logic [7:0]      addr,
  input  logic            rd,
  input  logic            wr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [PINS-1:0] pin_i,
  output logic [PINS-1:0] pin_o,
  output logic [PINS-1:0] pin_oe,
  output logic            irq
);

  logic [PINS-1:0] sync_in, rise, fall;
  logic [PINS-1:0] out_reg, oe_reg, rise_en_reg, fall_en_reg, flag_reg, irq_en_reg;
  logic [PINS-1:0] out_next, oe_next, rise_en_next, fall_en_next, flag_next, irq_en_next;
  logic [PINS-1:0] clr_mask, bit_mask, wd;
  logic [31:0]     rdata_reg, rdata_next, bit_vec, word_val;
  logic            irq_reg;
  fn_e             fn;
  logic [2:0]      wreg;
  logic [4:0]      p;
  logic            wr_en, rd_en;
  logic            unused_wdata;

  gpio_sync #(.WIDTH(PINS), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .resetq  (resetq),
    .din     (pin_i),
    .sync_in (sync_in),
    .rise    (rise),
    .fall    (fall)
  );

  assign fn           = fn_e'(addr[7:5]);
  assign wreg         = addr[4:2];
  assign p            = addr[4:0];
  assign wr_en        = sel & wr;
  assign rd_en        = sel & rd;
  // Pins at or beyond PINS fall off the top of the mask, so those accesses are no-ops.
  assign bit_mask     = PINS'(32'd1 << p);
  assign wd           = PINS'(wdata);
  assign unused_wdata = ^wdata;

  function automatic logic [PINS-1:0] put_bit(logic [PINS-1:0] v, logic [PINS-1:0] m, logic b);
    return b ? (v | m) : (v & ~m);
  endfunction

  always_comb begin
    out_next     = out_reg;
    oe_next      = oe_reg;
    rise_en_next = rise_en_reg;
    fall_en_next = fall_en_reg;
    irq_en_next  = irq_en_reg;
    clr_mask     = '0;
    if (wr_en) begin
      case (fn)
        FN_PIN:  out_next     = put_bit(out_reg, bit_mask, wdata[0]);
        FN_DIR:  oe_next      = put_bit(oe_reg, bit_mask, wdata[0]);
        FN_RISE: rise_en_next = put_bit(rise_en_reg, bit_mask, wdata[0]);
        FN_FALL: fall_en_next = put_bit(fall_en_reg, bit_mask, wdata[0]);
        FN_FLAG: if (wdata[0]) clr_mask = bit_mask;
        FN_WORD: begin
          case (wreg)
            W_OUT:   out_next    = wd;
            W_DIR:   oe_next     = wd;
            W_SET:   out_next    = out_reg | wd;
            W_CLR:   out_next    = out_reg & ~wd;
            W_TGL:   out_next    = out_reg ^ wd;
            W_FLAG:  clr_mask    = wd;
            W_IRQEN: irq_en_next = wd;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
    // OR-ing events in after the clear makes a coincident set win.
    flag_next = (flag_reg & ~clr_mask) | (rise & rise_en_reg) | (fall & fall_en_reg);
  end

  always_comb begin
    bit_vec  = '0;
    word_val = '0;
    case (fn)
      FN_PIN:  bit_vec = 32'(sync_in);
      FN_DIR:  bit_vec = 32'(oe_reg);
      FN_RISE: bit_vec = 32'(rise_en_reg);
      FN_FALL: bit_vec = 32'(fall_en_reg);
      FN_FLAG: bit_vec = 32'(flag_reg);
      default: ;
    endcase
    case (wreg)
      W_IN:    word_val = 32'(sync_in);
      W_OUT:   word_val = 32'(out_reg);
      W_DIR:   word_val = 32'(oe_reg);
      W_FLAG:  word_val = 32'(flag_reg);
      W_IRQEN: word_val = 32'(irq_en_reg);
      default: ;
    endcase
    if (fn == FN_WORD) rdata_next = word_val;
    else               rdata_next = {31'b0, bit_vec[p]};
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      out_reg     <= OUT_RESET[PINS-1:0];
      oe_reg      <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      flag_reg    <= '0;
      irq_en_reg  <= '0;
      rdata_reg   <= '0;
      irq_reg     <= 1'b0;
    end else begin
      out_reg     <= out_next;
      oe_reg      <= oe_next;
      rise_en_reg <= rise_en_next;
      fall_en_reg <= fall_en_next;
      flag_reg    <= flag_next;
      irq_en_reg  <= irq_en_next;
      if (rd_en) rdata_reg <= rdata_next;
      irq_reg     <= |(flag_reg & irq_en_reg);
    end
  end

  assign rdata  = rdata_reg;
  assign pin_o  = out_reg;
  assign pin_oe = oe_reg;
  assign irq    = irq_reg;

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: directed register/edge/reset scenarios and random bus
// traffic, all checked every cycle against a behavioural register-map model.
module tb_gpio_bank;

  localparam int          PINS  = 28;
  localparam int          SS    = 2;
  localparam logic [31:0] OUTR  = 32'h5;
  localparam logic [31:0] PMASK = 32'h0FFF_FFFF;

  logic            clk = 1'b0;
  logic            resetq = 1'b0;
  logic            sel = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0]      addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic [PINS-1:0] pin_i = '0;
  logic [PINS-1:0] pin_o, pin_oe;
  logic            irq;

  int total = 0;
  int bad   = 0;

  gpio_bank #(.PINS(PINS), .SYNC_STAGES(SS), .OUT_RESET(OUTR)) dut (
    .clk    (clk),
    .resetq (resetq),
    .sel    (sel),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .wdata  (wdata),
    .rdata  (rdata),
    .pin_i  (pin_i),
    .pin_o  (pin_o),
    .pin_oe (pin_oe),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Model state: register contents as plain 32-bit words, pad history newest first.
  logic [31:0] m_out, m_oe, m_ren, m_fen, m_flag, m_ien, m_rdata;
  logic        m_irq;
  logic [31:0] hist [0:SS];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_out = OUTR & PMASK; m_oe = '0; m_ren = '0; m_fen = '0;
    m_flag = '0; m_ien = '0; m_rdata = '0; m_irq = 1'b0;
    for (int k = 0; k <= SS; k++) hist[k] = '0;
  endtask

  function automatic logic [31:0] m_read(logic [7:0] a, logic [31:0] s);
    logic [31:0] v;
    int          pi;
    pi = int'(a[4:0]);
    case (a[7:5])
      3'd0: v = s;
      3'd1: v = m_oe;
      3'd2: v = m_ren;
      3'd3: v = m_fen;
      3'd4: v = m_flag;
      3'd5: begin
        case (a[4:2])
          3'd0: return s;
          3'd1: return m_out;
          3'd2: return m_oe;
          3'd6: return m_flag;
          3'd7: return m_ien;
          default: return 32'd0;
        endcase
      end
      default: return 32'd0;
    endcase
    return (pi < PINS) ? {31'b0, v[pi]} : 32'd0;
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic m_apply();
    logic [31:0] s, pv, ev, clr, wd;
    logic [2:0]  fn;
    int          pi;
    logic        irq_n;
    if (!resetq) return;
    s     = hist[SS-1];
    pv    = hist[SS];
    ev    = (s & ~pv & m_ren) | (~s & pv & m_fen);
    irq_n = |(m_flag & m_ien);
    if (sel && rd) m_rdata = m_read(addr, s);
    clr = '0;
    wd  = wdata & PMASK;
    fn  = addr[7:5];
    pi  = int'(addr[4:0]);
    if (sel && wr) begin
      if (fn <= 3'd4) begin
        if (pi < PINS) begin
          case (fn)
            3'd0: m_out[pi] = wdata[0];
            3'd1: m_oe[pi]  = wdata[0];
            3'd2: m_ren[pi] = wdata[0];
            3'd3: m_fen[pi] = wdata[0];
            default: clr[pi] = wdata[0];
          endcase
        end
      end else if (fn == 3'd5) begin
        case (addr[4:2])
          3'd1: m_out = wd;
          3'd2: m_oe  = wd;
          3'd3: m_out = m_out | wd;
          3'd4: m_out = m_out & ~wd;
          3'd5: m_out = m_out ^ wd;
          3'd6: clr   = wd;
          3'd7: m_ien = wd;
          default: ;
        endcase
      end
    end
    m_flag = (m_flag & ~clr) | ev;
    m_irq  = irq_n;
    for (int k = SS; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = 32'(pin_i);
  endtask

  task automatic step();
    @(posedge clk);
    m_apply();
    #1;
  endtask

  task automatic bus_wr(logic [7:0] a, logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    step();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(logic [7:0] a);
    sel = 1'b1; rd = 1'b1; addr = a;
    step();
    sel = 1'b0; rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (resetq) begin
      check("rdata", rdata, m_rdata);
      check("pin_o", 32'(pin_o), m_out);
      check("pin_oe", 32'(pin_oe), m_oe);
      check("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  initial begin
    m_reset();
    repeat (3) step();
    resetq = 1'b1;
    check("rst_pin_o", 32'(pin_o), 32'h5);
    check("rst_pin_oe", 32'(pin_oe), 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", rdata, 32'h0);

    bus_rd(8'hA4);
    check("rd_word_out", rdata, 32'h5);

    // Simultaneous read and write: read returns the old value.
    sel = 1'b1; rd = 1'b1; wr = 1'b1; addr = 8'hA4; wdata = 32'hFFFF_FF33;
    step();
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    check("rdwr_old", rdata, 32'h5);
    check("rdwr_new", 32'(pin_o), 32'h0FFF_FF33);

    bus_wr(8'hA4, 32'h0);
    bus_wr(8'hA8, 32'hFFFF_FFFF);
    bus_wr(8'hAC, 32'h0000_00F0);
    bus_wr(8'hB0, 32'h0000_0030);
    bus_wr(8'hB4, 32'h0000_0001);
    check("set_clr_tgl", 32'(pin_o), 32'h0C1);
    check("dir_all", 32'(pin_oe), 32'h0FFF_FFFF);
    bus_rd(8'hA8);
    check("rd_word_dir", rdata, 32'h0FFF_FFFF);

    bus_wr(8'h1B, 32'h1);
    check("bit27", 32'(pin_o), 32'h0800_00C1);
    bus_wr(8'h1E, 32'h1);
    check("bit30_wr", 32'(pin_o), 32'h0800_00C1);
    bus_rd(8'h1E);
    check("bit30_rd", rdata, 32'h0);

    // Rising edge on pin 3 with rise_en[3] and irq_en[3].
    bus_wr(8'h43, 32'h1);
    bus_wr(8'hBC, 32'h8);
    pin_i[3] = 1'b1;
    step(); step();
    check("rise_irq_e2", {31'b0, irq}, 32'h0);
    step();
    check("rise_irq_e3", {31'b0, irq}, 32'h0);
    step();
    check("rise_irq_e4", {31'b0, irq}, 32'h1);
    bus_wr(8'hB8, 32'h8);
    step();
    check("w1c_irq", {31'b0, irq}, 32'h0);
    bus_rd(8'hB8);
    check("w1c_flags", rdata, 32'h0);

    // Falling edge on pin 5 coinciding with a W1C of the same bit.
    pin_i[5] = 1'b1;
    bus_wr(8'h65, 32'h1);
    repeat (3) step();
    pin_i[5] = 1'b0;
    step(); step();
    bus_wr(8'hB8, 32'h20);
    bus_rd(8'hB8);
    check("set_wins", rdata, 32'h20);
    bus_wr(8'hBC, 32'h28);
    step();
    check("irq_pin5", {31'b0, irq}, 32'h1);

    // Asynchronous reset in the middle of activity.
    resetq = 1'b0;
    m_reset();
    #2;
    check("arst_irq", {31'b0, irq}, 32'h0);
    check("arst_oe", 32'(pin_oe), 32'h0);
    check("arst_rdata", rdata, 32'h0);
    check("arst_pin_o", 32'(pin_o), 32'h5);
    step(); step();
    resetq = 1'b1;
    pin_i[5] = 1'b1; pin_i[3] = 1'b0;
    repeat (5) step();
    pin_i[5] = 1'b0; pin_i[3] = 1'b1;
    repeat (5) step();
    check("post_rst_irq", {31'b0, irq}, 32'h0);
    bus_rd(8'hB8);
    check("post_rst_flags", rdata, 32'h0);

    // Random bus traffic and pad activity against the model.
    for (int n = 0; n < 2000; n++) begin
      sel   = ($urandom_range(0, 4) != 0);
      rd    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      addr  = 8'($urandom);
      wdata = $urandom;
      if ($urandom_range(0, 2) == 0) pin_i = pin_i ^ PINS'($urandom);
      step();
    end
    sel = 1'b0; rd = 1'b0; wr = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised GPIO bank for the j1 SoC IO space; successor to the fixed 28-pin gp/gn bit-addressed logic in the board top.
- Adds configurable pin count, input synchronisation, word-wide access, atomic set/clear/toggle, per-pin rise/fall event capture and a maskable interrupt.
- The top-level decoder instantiates one bank per header (gp, gn) and drives sel from the upper address bits.
- Pads, with the tristate from pin_o/pin_oe, stay in the top level.

Parameters:
- PINS, 28, number of pins in the bank; legal range 1..32.
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser; must be at least 2.
- OUT_RESET, 32'd0, reset value of the output register; only bits [PINS-1:0] are used.

Ports:
- clk  input  1  system clock
- resetq  input  1  asynchronous active-low reset
- sel  input  1  bank selected; qualifies rd and wr
- addr  input  8  [7:5] function, [4:0] pin index or word register
- rd  input  1  read strobe
- wr  input  1  write strobe
- wdata  input  32  write data
- rdata  output  32  registered read data
- pin_i  input  PINS  raw pad inputs, asynchronous
- pin_o  output  PINS  output values
- pin_oe  output  PINS  output enables (1 = drive)
- irq  output  1  registered interrupt request

Behaviour:
- Reset, asynchronous, while resetq is 0:
  - rdata = 0, pin_o = OUT_RESET[PINS-1:0], pin_oe = 0 (all pins input), irq = 0.
  - Synchroniser chain, previous-sample register, rise_en, fall_en, event flags and irq_en all cleared.
- Input path:
  - pin_i passes through SYNC_STAGES flops to give sync_in.
  - prev <= sync_in every cycle.
  - rise = sync_in & ~prev; fall = ~sync_in & prev.
  - Edges are detected on every pin regardless of direction.
- Bit-access functions (addr[7:5]), pin index p = addr[4:0]. Reads return the bit zero-extended; writes use wdata[0].
  - 0: rd sync_in[p] / wr pin_o[p]
  - 1: pin_oe[p]
  - 2: rise_en[p]
  - 3: fall_en[p]
  - 4: rd flag[p] / wr 1 clears flag[p], wr 0 no effect
- Word function 5, register r = addr[4:2]; addr[1:0] ignored:
  - 0: rd sync_in; writes ignored
  - 1: pin_o, rd/wr
  - 2: pin_oe, rd/wr
  - 3: SET, wr only; pin_o |= wdata
  - 4: CLR, wr only; pin_o &= ~wdata
  - 5: TGL, wr only; pin_o ^= wdata
  - 6: flags, rd; wr 1 clears the corresponding bits
  - 7: irq_en, rd/wr
  - Write-only registers read as 0.
- Functions 6 and 7: reads return 0, writes are ignored.
- Unimplemented bits:
  - p >= PINS: reads return 0, writes are ignored.
  - Word reads zero bits [31:PINS]; word writes ignore bits [31:PINS].
- Write timing: a write takes effect at the clock edge where sel & wr is high. pin_o and pin_oe change one cycle after the strobe.
- Read timing:
  - When sel & rd is high, rdata loads at that edge, giving 1-cycle latency. Otherwise rdata holds.
  - Readback reflects state before any same-cycle write.
  - rd and wr may be high together; the read returns old state.
- Event flags:
  - flag[i] sets on (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]).
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq <= |(flag & irq_en), registered, so irq lags flag by one cycle.
- Total latency from a pad edge to irq is SYNC_STAGES+2 cycles.
- Reset mid-operation: all state clears immediately. Because enables reset to 0, no events can be generated until software re-enables them.

Decomposition:
- Package gpio_pkg holds:
  - function codes FN_PIN, FN_DIR, FN_RISE, FN_FALL, FN_FLAG, FN_WORD
  - word register offsets W_IN, W_OUT, W_DIR, W_SET, W_CLR, W_TGL, W_FLAG, W_IRQEN
- One sub-module, gpio_sync, parametrised on WIDTH and STAGES: the synchroniser chain plus the prev register, with sync_in, rise and fall as outputs.

Test Plan:
- Reset with OUT_RESET = 32'h5 and PINS = 28 -> pin_o = 28'h5, pin_oe = 0, irq = 0. A read of word 1 returns 32'h5 on the cycle after rd.
- Write word 2 = 32'hFFFF_FFFF, then SET 32'h0000_00F0, CLR 32'h0000_0030, TGL 32'h0000_0001 -> pin_oe = 28'hFFF_FFFF and pin_o = 28'h0C1 (from reset 0). A read of word 2 returns 32'h0FFF_FFFF.
- Bit write addr = {3'd0, 5'd27} with wdata = 1 -> pin_o[27] = 1. A bit write to pin 30 is ignored, and a read of pin 30 returns 0.
- Set rise_en[3] = 1 and irq_en = 32'h8, then drive pin_i[3] 0->1 -> flag[3] = 1 after SYNC_STAGES+1 cycles and irq = 1 one cycle later. W1C word 6 with 32'h8 -> flag and irq drop.
- Set fall_en[5] = 1, then in the same cycle the falling edge registers, write W1C 32'h20 -> flag[5] stays 1 (set wins).
- Set flags, then pulse resetq low mid-sequence -> flags, irq, pin_oe and rdata are 0 immediately, asynchronously. A subsequent pin toggle raises no flag.
